// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W            = 16;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned MEM_BYTES_DEFAULT = 2048;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_BYTE = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  // Request attributes that must survive past the accept edge.
  typedef struct packed {
    logic write;
    logic is_byte;
    logic sign_ext;
  } lsu_ctl_t;

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus data-memory pins of the load/store unit.
interface lsu_if import lsu_pkg::*; ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_fault;

  logic              mem_rd;
  logic              mem_wn;
  logic [ADDR_W-1:0] mem_address;
  logic [1:0]        mem_mode;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_rd, mem_wn, mem_address, mem_mode, mem_write_data
  );

  modport memory (
    input  mem_rd, mem_wn, mem_address, mem_mode, mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Formats raw memory read data into the load result (word pass-through or byte extend).
module lsu_load_extend import lsu_pkg::*; (
  input  logic [DATA_W-1:0] raw,
  input  logic              is_byte,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] data_c
);

  // Byte loads arrive in [7:0]; upper byte is sign or zero fill.
  always_comb begin
    data_c = raw;
    if (is_byte) begin
      data_c = {{8{sign_ext & raw[7]}}, raw[7:0]};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sequenced against the
// memory's posedge-read / negedge-write timing, single-cycle response pulse.
module load_store_unit import lsu_pkg::*; #(
  parameter int unsigned MEM_BYTES   = MEM_BYTES_DEFAULT,
  parameter bit          ALIGN_CHECK = 1'b0
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  lsu_state_e state_q, state_d;
  lsu_ctl_t   ctl_q, ctl_d;

  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_fault_q, resp_fault_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wn_q, mem_wn_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [1:0]        mem_mode_q, mem_mode_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              fault_c;
  logic [31:0]       addr_ext_c;
  logic [DATA_W-1:0] load_data_c;

  lsu_load_extend u_load_extend (
    .raw      (bus.mem_read_data),
    .is_byte  (ctl_q.is_byte),
    .sign_ext (ctl_q.sign_ext),
    .data_c   (load_data_c)
  );

  // Reject out-of-range, last-byte word and (optionally) misaligned word accesses.
  always_comb begin
    addr_ext_c = 32'(bus.req_addr);
    fault_c    = (addr_ext_c >= MEM_BYTES)
              || (!bus.req_byte && (addr_ext_c == (MEM_BYTES - 32'd1)))
              || (ALIGN_CHECK && !bus.req_byte && bus.req_addr[0]);
  end

  always_comb begin
    state_d       = state_q;
    ctl_d         = ctl_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = '0;
    resp_fault_d  = 1'b0;
    mem_rd_d      = 1'b0;
    mem_wn_d      = 1'b0;
    mem_address_d = mem_address_q;
    mem_mode_d    = mem_mode_q;
    mem_wdata_d   = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          ctl_d.write    = bus.req_write;
          ctl_d.is_byte  = bus.req_byte;
          ctl_d.sign_ext = bus.req_signed;
          if (fault_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d       = ISSUE;
            mem_address_d = bus.req_addr;
            mem_mode_d    = bus.req_byte ? MODE_BYTE : MODE_WORD;
            mem_rd_d      = !bus.req_write;
            mem_wn_d      = bus.req_write;
            if (bus.req_write) begin
              mem_wdata_d = bus.req_byte ? {8'h00, bus.req_wdata[7:0]} : bus.req_wdata;
            end
          end
        end
      end
      // Memory acts during this cycle; strobes drop on the way out.
      ISSUE: begin
        if (ctl_q.write) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data_c;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ctl_q         <= '0;
      ready_q       <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_fault_q  <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wn_q      <= 1'b0;
      mem_address_q <= '0;
      mem_mode_q    <= MODE_WORD;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      ctl_q         <= ctl_d;
      ready_q       <= ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_fault_q  <= resp_fault_d;
      mem_rd_q      <= mem_rd_d;
      mem_wn_q      <= mem_wn_d;
      mem_address_q <= mem_address_d;
      mem_mode_q    <= mem_mode_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.req_ready      = ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_fault     = resp_fault_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_wn         = mem_wn_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_mode       = mem_mode_q;
  assign bus.mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: two units (alignment check off/on) over one byte memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [15:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   resp0_cnt = 0;
  int   rdwn0_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] mem [0:2047];
  bit         mem_loaded = 1'b0;

  lsu_if bus0();
  lsu_if bus1();

  load_store_unit #(.MEM_BYTES(2048), .ALIGN_CHECK(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  load_store_unit #(.MEM_BYTES(2048), .ALIGN_CHECK(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_rd_fn(input logic [15:0] a, input logic [1:0] m);
    logic [10:0] i;
    i = a[10:0];
    if (m == MODE_BYTE) return {8'h00, mem[i]};
    return {mem[i], mem[i + 11'd1]};
  endfunction

  // Memory model: registered read on posedge, write on negedge (only dut0 stores).
  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
      mem_loaded = 1'b1;
    end
    if (bus0.mem_wn && bus0.mem_address < 16'd2048) begin
      if (bus0.mem_mode == MODE_BYTE) begin
        mem[bus0.mem_address[10:0]] = bus0.mem_write_data[7:0];
      end else begin
        mem[bus0.mem_address[10:0]]         = bus0.mem_write_data[15:8];
        mem[bus0.mem_address[10:0] + 11'd1] = bus0.mem_write_data[7:0];
      end
    end
  end

  always @(posedge clk) begin
    if (bus0.mem_rd) bus0.mem_read_data <= mem_rd_fn(bus0.mem_address, bus0.mem_mode);
    if (bus1.mem_rd) bus1.mem_read_data <= mem_rd_fn(bus1.mem_address, bus1.mem_mode);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void cmp_resp(input string nm, input exp_t e, input logic [15:0] rd,
                                   input logic f, input int now);
    checks++;
    if (rd !== e.rdata || f !== e.fault || (now - e.acc) != e.lat) begin
      errors++;
      $display("FAIL %s: got rdata=%h fault=%b lat=%0d expected rdata=%h fault=%b lat=%0d",
               nm, rd, f, now - e.acc, e.rdata, e.fault, e.lat);
    end
  endfunction

  // Monitors: pop and compare on every response pulse; check memory strobe legality.
  always @(negedge clk) begin
    if (bus0.resp_valid) begin
      resp0_cnt++;
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp0_unexpected: got rdata=%h fault=%b expected no response",
                 bus0.resp_rdata, bus0.resp_fault);
      end else begin
        cmp_resp("resp0", q0.pop_front(), bus0.resp_rdata, bus0.resp_fault, cyc);
      end
    end
    if (bus0.mem_rd || bus0.mem_wn) begin
      rdwn0_cnt++;
      checks++;
      if ((bus0.mem_rd && bus0.mem_wn) || bus0.mem_mode[1]) begin
        errors++;
        $display("FAIL strobe0: got rd=%b wn=%b mode=%b expected exclusive strobes, mode<2",
                 bus0.mem_rd, bus0.mem_wn, bus0.mem_mode);
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.resp_valid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp1_unexpected: got rdata=%h fault=%b expected no response",
                 bus1.resp_rdata, bus1.resp_fault);
      end else begin
        cmp_resp("resp1", q1.pop_front(), bus1.resp_rdata, bus1.resp_fault, cyc);
      end
    end
  end

  // Present a request from a negedge, wait (bounded) for acceptance, push expectation.
  task automatic issue(input int sel, input logic wr, input logic by, input logic sg,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rd, input logic exp_f, input int exp_lat,
                       input bit push);
    int   n;
    logic rdy;
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      bus0.req_write = wr; bus0.req_byte = by; bus0.req_signed = sg;
      bus0.req_addr = addr; bus0.req_wdata = wdata; bus0.req_valid = 1'b1;
    end else begin
      bus1.req_write = wr; bus1.req_byte = by; bus1.req_signed = sg;
      bus1.req_addr = addr; bus1.req_wdata = wdata; bus1.req_valid = 1'b1;
    end
    n = 0;
    rdy = (sel == 0) ? bus0.req_ready : bus1.req_ready;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = (sel == 0) ? bus0.req_ready : bus1.req_ready;
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 after %0d cycles expected 1", n);
      bus0.req_valid = 1'b0;
      bus1.req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rd; e.fault = exp_f; e.lat = exp_lat; e.acc = cyc;
    if (push) begin
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    bus0.req_valid = 1'b0;
    bus1.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus0.req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(bus0.resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, 32'(bus0.resp_rdata), 32'd0);
    chk({tag, "_resp_fault"}, 32'(bus0.resp_fault), 32'd0);
    chk({tag, "_mem_rd_wn"}, 32'({bus0.mem_rd, bus0.mem_wn}), 32'd0);
    chk({tag, "_mem_address"}, 32'(bus0.mem_address), 32'd0);
    chk({tag, "_mem_mode"}, 32'(bus0.mem_mode), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus0.mem_write_data), 32'd0);
  endtask

  initial begin
    int base_rdwn;
    int base_resp;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_byte = 1'b0;
    bus0.req_signed = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_byte = 1'b0;
    bus1.req_signed = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;

    // Word store then word load, big-endian byte placement
    issue(0, 1, 0, 0, 16'h0010, 16'hBEEF, 16'h0000, 0, 2, 1); drop();
    issue(0, 0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 3, 1); drop();
    drain();
    chk("mem_10", 32'(mem[16]), 32'hBE);
    chk("mem_11", 32'(mem[17]), 32'hEF);

    // Byte store, signed and unsigned byte loads
    issue(0, 1, 1, 0, 16'h0021, 16'h1280, 16'h0000, 0, 2, 1); drop();
    issue(0, 0, 1, 1, 16'h0021, 16'h0000, 16'hFF80, 0, 3, 1); drop();
    issue(0, 0, 1, 0, 16'h0021, 16'h0000, 16'h0080, 0, 3, 1); drop();
    drain();
    chk("mem_21", 32'(mem[33]), 32'h80);
    chk("mem_22", 32'(mem[34]), 32'h22);

    // Range faults: no memory strobes, 1-cycle response
    base_rdwn = rdwn0_cnt;
    issue(0, 0, 0, 0, 16'h07FF, 16'h0000, 16'h0000, 1, 1, 1); drop();
    issue(0, 1, 1, 0, 16'h0800, 16'h00AA, 16'h0000, 1, 1, 1); drop();
    issue(0, 0, 1, 0, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 1); drop();
    drain();
    chk("fault_no_strobe", 32'(rdwn0_cnt - base_rdwn), 32'd0);
    issue(0, 0, 1, 0, 16'h07FF, 16'h0000, 16'h00FF, 0, 3, 1); drop();

    // Odd word address: allowed without alignment check, faults with it
    issue(0, 0, 0, 0, 16'h0013, 16'h0000, 16'h1314, 0, 3, 1); drop();
    issue(1, 0, 0, 0, 16'h0013, 16'h0000, 16'h0000, 1, 1, 1); drop();
    issue(1, 0, 1, 0, 16'h0013, 16'h0000, 16'h0013, 0, 3, 1); drop();
    issue(1, 0, 1, 1, 16'h0021, 16'h0000, 16'hFF80, 0, 3, 1); drop();
    issue(1, 0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 3, 1); drop();
    drain();

    // Three stores with req_valid held high throughout
    base_resp = resp0_cnt;
    issue(0, 1, 0, 0, 16'h0030, 16'h1111, 16'h0000, 0, 2, 1);
    issue(0, 1, 1, 0, 16'h0032, 16'h22AB, 16'h0000, 0, 2, 1);
    issue(0, 1, 0, 0, 16'h0034, 16'h3344, 16'h0000, 0, 2, 1);
    drop();
    drain();
    chk("queued_resp_count", 32'(resp0_cnt - base_resp), 32'd3);
    chk("mem_30_31", 32'({mem[48], mem[49]}), 32'h1111);
    chk("mem_32_33", 32'({mem[50], mem[51]}), 32'hAB33);
    chk("mem_34_35", 32'({mem[52], mem[53]}), 32'h3344);

    // Reset between accept edge and the write negedge aborts the store
    issue(0, 1, 0, 0, 16'h0040, 16'h5555, 16'h0000, 0, 2, 1); drop();
    drain();
    base_resp = resp0_cnt;
    issue(0, 1, 0, 0, 16'h0040, 16'hAAAA, 16'h0000, 0, 2, 0);
    #1 rst = 1'b1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_resp", 32'(resp0_cnt - base_resp), 32'd0);
    chk("mem_40_41", 32'({mem[64], mem[65]}), 32'h5555);
    issue(0, 0, 0, 0, 16'h0040, 16'h0000, 16'h5555, 0, 3, 1); drop();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
